// File: rtl/mem_stage.sv
// mem_stage: load/store stage with a req/ack data-memory port and a single write-back slot.
// Non-memory and misaligned instructions bypass the bus and complete in one cycle.
module mem_stage #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_res,
    input  logic [31:0] B_res,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic        reg_write,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        misalign_err,
    output logic        bus_err
);
    typedef enum logic [1:0] {IDLE, ACCESS, FULL} state_t;
    localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);
    state_t      state, state_d;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic [4:0]  rd_q;
    logic        rw_q;
    logic [7:0]  cnt;
    logic        accept, is_mem, misal, timeout, done;
    logic [31:0] lane, load_val;
    assign in_ready  = state == IDLE || (state == FULL && out_ready);
    assign accept    = in_valid && in_ready;
    assign is_mem    = mem_read || mem_write;
    assign misal     = is_mem && (funct3[1] ? |alu_res[1:0] : funct3[0] && alu_res[0]);
    assign timeout   = ACK_TIMEOUT != 0 && !dmem_ack && cnt == TO_LAST;
    assign done      = state == ACCESS && (dmem_ack || timeout);
    assign dmem_req  = state == ACCESS;
    assign out_valid = state == FULL;
    // Byte offset selects the lane; f3_q[2] marks the zero-extending variants.
    assign lane      = dmem_rdata >> {off_q, 3'b000};
    assign load_val  = f3_q[1] ? dmem_rdata :
                       f3_q[0] ? {{16{lane[15] & ~f3_q[2]}}, lane[15:0]} :
                                 {{24{lane[7] & ~f3_q[2]}}, lane[7:0]};
    always_comb begin
        state_d = state;
        if (accept)
            state_d = is_mem && !misal ? ACCESS : FULL;
        else if (done)
            state_d = FULL;
        else if (state == FULL && out_ready)
            state_d = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            off_q        <= '0;
            f3_q         <= '0;
            rd_q         <= '0;
            rw_q         <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_be      <= '0;
            dmem_wdata   <= '0;
            wb_data      <= '0;
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= state == ACCESS && state_d == ACCESS ? cnt + 8'd1 : 8'd0;
            if (accept) begin
                dmem_addr    <= {alu_res[31:2], 2'b00};
                dmem_we      <= mem_write;
                dmem_be      <= funct3[1] ? 4'b1111 :
                                funct3[0] ? (alu_res[1] ? 4'b1100 : 4'b0011) :
                                            4'b0001 << alu_res[1:0];
                dmem_wdata   <= funct3[1] ? B_res : funct3[0] ? {2{B_res[15:0]}} : {4{B_res[7:0]}};
                off_q        <= alu_res[1:0];
                f3_q         <= funct3;
                rd_q         <= rd;
                rw_q         <= reg_write;
                wb_data      <= alu_res;
                wb_rd        <= rd;
                wb_reg_write <= reg_write && !misal;
                misalign_err <= misal;
                bus_err      <= 1'b0;
            end else if (done) begin
                wb_data      <= dmem_ack && !dmem_we ? load_val : {dmem_addr[31:2], off_q};
                wb_rd        <= rd_q;
                wb_reg_write <= dmem_ack && !dmem_we && rw_q;
                bus_err      <= !dmem_ack;
            end else if (state == FULL && out_ready) begin
                wb_reg_write <= 1'b0;
                misalign_err <= 1'b0;
                bus_err      <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and random load/store/ALU instructions checked against a transaction-level model.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] alu_res, B_res;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        reg_write;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        out_valid, out_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write, misalign_err, bus_err;
    int n_checks = 0;
    int n_fail = 0;

    mem_stage #(.ACK_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_res(alu_res), .B_res(B_res), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .rd(rd), .reg_write(reg_write), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_reg_write(wb_reg_write), .misalign_err(misalign_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One complete instruction; ack arrives in ACCESS cycle d (d > 4 means never, so it times out).
    task automatic do_op(input logic [31:0] alu, input logic [31:0] b, input logic mr, input logic mw,
                         input logic [2:0] f3, input logic [4:0] rdi, input logic rw, input int d,
                         input logic [31:0] rdat);
        int size, off, cyc;
        logic is_mem, mis;
        logic [31:0] exp_be, exp_wd, v;
        @(negedge clk);
        check("idle_ov", 32'(out_valid), 32'd0);
        in_valid = 1; alu_res = alu; B_res = b; mem_read = mr; mem_write = mw;
        funct3 = f3; rd = rdi; reg_write = rw; out_ready = 1; dmem_rdata = rdat;
        #1 check("idle_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 0;
        is_mem = mr | mw;
        size = f3[1:0] == 2'b10 ? 4 : f3[1:0] == 2'b01 ? 2 : 1;
        off = int'(alu[1:0]);
        mis = is_mem && (off % size != 0);
        exp_be = 0;
        exp_wd = 0;
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + size) exp_be[i] = 1'b1;
            exp_wd[8*i +: 8] = b[8*(i % size) +: 8];
        end
        cyc = 0;
        if (is_mem && !mis) begin
            while (dmem_req === 1'b1 && cyc < 20) begin
                cyc++;
                check("addr", dmem_addr, alu & 32'hFFFF_FFFC);
                check("we", 32'(dmem_we), 32'(mw));
                check("be", 32'(dmem_be), exp_be);
                if (mw) check("wdata", dmem_wdata, exp_wd);
                dmem_ack = (cyc == d);
                @(negedge clk);
                dmem_ack = 0;
            end
            check("req_cycles", 32'(cyc), 32'(d <= 4 ? d : 4));
        end else
            check("no_req", 32'(dmem_req), 32'd0);
        check("ov", 32'(out_valid), 32'd1);
        check("misalign", 32'(misalign_err), 32'(mis));
        check("bus_err", 32'(bus_err), 32'(is_mem && !mis && d > 4));
        if (!is_mem || mis) begin
            check("wb_data", wb_data, alu);
            check("wb_rd", 32'(wb_rd), 32'(rdi));
            check("wb_rw", 32'(wb_reg_write), 32'(rw && !mis));
        end else if (d > 4 || mw)
            check("wb_rw_nold", 32'(wb_reg_write), 32'd0);
        else begin
            v = rdat >> (8 * off);
            v = size == 4 ? rdat : size == 2 ? v & 32'hFFFF : v & 32'hFF;
            if (!f3[2] && size == 2 && v >= 32'h8000) v = v - 32'h1_0000;
            if (!f3[2] && size == 1 && v >= 32'h80) v = v - 32'h100;
            check("load_data", wb_data, v);
            check("load_rd", 32'(wb_rd), 32'(rdi));
            check("load_rw", 32'(wb_reg_write), 32'(rw));
        end
    endtask

    initial begin
        logic [2:0] f3_tab [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [31:0] a;
        int kind;
        rst_n = 0; in_valid = 0; alu_res = 0; B_res = 0; mem_read = 0; mem_write = 0;
        funct3 = 0; rd = 0; reg_write = 0; dmem_ack = 0; dmem_rdata = 0; out_ready = 0;
        repeat (2) @(negedge clk);
        check("rst_ov", 32'(out_valid), 32'd0);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_wb", wb_data, 32'd0);
        check("rst_err", 32'({misalign_err, bus_err, wb_reg_write}), 32'd0);
        rst_n = 1;
        do_op(32'h0000_1234, 32'h0, 0, 0, 3'b000, 5'd5, 1, 1, 32'h0);
        do_op(32'h0000_0103, 32'h0, 1, 0, 3'b000, 5'd7, 1, 3, 32'h80AA_BBCC);
        check("lb_val", wb_data, 32'hFFFF_FF80);
        do_op(32'h0000_0103, 32'h0, 1, 0, 3'b100, 5'd7, 1, 3, 32'h80AA_BBCC);
        check("lbu_val", wb_data, 32'h0000_0080);
        do_op(32'h0000_0202, 32'h1234_5678, 0, 1, 3'b001, 5'd3, 1, 2, 32'h0);
        do_op(32'h0000_0006, 32'h0, 1, 0, 3'b010, 5'd9, 1, 1, 32'h0);
        do_op(32'h0000_0040, 32'h0, 1, 0, 3'b010, 5'd2, 1, 6, 32'h0);
        do_op(32'h0000_0041, 32'hA5, 1, 1, 3'b000, 5'd2, 1, 4, 32'h0);
        // back-to-back, then a held slot
        @(negedge clk);
        out_ready = 1; in_valid = 1; mem_read = 0; mem_write = 0; reg_write = 1;
        for (int i = 0; i < 3; i++) begin
            alu_res = 32'h100 + i;
            rd = 5'(i + 1);
            @(negedge clk);
            check("b2b_ov", 32'(out_valid), 32'd1);
            check("b2b_ready", 32'(in_ready), 32'd1);
            check("b2b_data", wb_data, 32'h100 + i);
        end
        alu_res = 32'h999;
        out_ready = 0;
        #1 check("hold_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("hold_data", wb_data, 32'h102);
        check("hold_ov", 32'(out_valid), 32'd1);
        out_ready = 1;
        #1 check("release_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("after_hold", wb_data, 32'h999);
        in_valid = 0;
        // reset in the middle of an access
        @(negedge clk);
        in_valid = 1; alu_res = 32'h80; mem_read = 1; mem_write = 0; funct3 = 3'b010;
        @(negedge clk);
        in_valid = 0;
        check("rst_req_before", 32'(dmem_req), 32'd1);
        #2 rst_n = 0;
        #1 check("rst_req_drop", 32'(dmem_req), 32'd0);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_no_retry", 32'(dmem_req | out_valid), 32'd0);
        end
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 3);
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            do_op(a, $urandom, kind == 1 || kind == 3, kind >= 2,
                  kind == 0 ? 3'b000 : f3_tab[$urandom_range(0, 4)],
                  5'($urandom), 1'($urandom), $urandom_range(1, 6), $urandom);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
